// File: rtl/ips2l_pcie_dma_rx_bar_router.sv
// Routes MWr and CplD write streams into per-BAR first-word-fall-through FIFOs.
// Optional per-BAR push counters are enabled by IPS2L_PCIE_DMA_RX_ROUTER_STAT_EN.
module ips2l_pcie_dma_rx_bar_router #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 9,
  parameter int BAR_NUM    = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_mwr_wr_vld,
  output logic                               o_mwr_wr_rdy,
  input  logic [1:0]                         i_mwr_wr_bar,
  input  logic [ADDR_WIDTH-1:0]              i_mwr_wr_addr,
  input  logic [DATA_WIDTH-1:0]              i_mwr_wr_data,
  input  logic [DATA_WIDTH/8-1:0]            i_mwr_wr_be,
  input  logic                               i_cpld_wr_vld,
  output logic                               o_cpld_wr_rdy,
  input  logic [1:0]                         i_cpld_wr_bar,
  input  logic [ADDR_WIDTH-1:0]              i_cpld_wr_addr,
  input  logic [DATA_WIDTH-1:0]              i_cpld_wr_data,
  input  logic [DATA_WIDTH/8-1:0]            i_cpld_wr_be,
  output logic [BAR_NUM-1:0]                 o_bar_wr_vld,
  input  logic [BAR_NUM-1:0]                 i_bar_wr_rdy,
  output logic [BAR_NUM*ADDR_WIDTH-1:0]      o_bar_wr_addr,
  output logic [BAR_NUM*DATA_WIDTH-1:0]      o_bar_wr_data,
  output logic [BAR_NUM*(DATA_WIDTH/8)-1:0]  o_bar_wr_be,
  output logic [15:0]                        o_drop_cnt,
  output logic [BAR_NUM*32-1:0]              o_bar_wr_cnt
);

  localparam int BE_W    = DATA_WIDTH / 8;
  localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH + BE_W;
  localparam int PTR_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [2:0] BAR_LIM = 3'(BAR_NUM);

  // Handshake: every port transfers on vld & rdy at the rising clk edge; the
  // source rdy is the arbiter grant and may depend combinationally on its vld.

  logic               rr_ptr_q, rr_ptr_d;  // 0: MWr wins next contest, 1: CplD
  logic [BAR_NUM-1:0] fifo_full;
  logic [BAR_NUM-1:0] push;
  logic [3:0]         full_ext;
  logic               mwr_in_range, cpld_in_range;
  logic               mwr_elig, cpld_elig;
  logic               grant_mwr, grant_cpld, grant_any;
  logic [1:0]         sel_bar;
  logic               sel_in_range;
  logic [ENTRY_W-1:0] sel_entry;
  logic               drop;
  logic [15:0]        drop_q, drop_d;

  always_comb begin
    full_ext                = '0;
    full_ext[BAR_NUM-1:0]   = fifo_full;
    mwr_in_range            = {1'b0, i_mwr_wr_bar} < BAR_LIM;
    cpld_in_range           = {1'b0, i_cpld_wr_bar} < BAR_LIM;
    // Out-of-range indices take the drop path, which can never back-pressure.
    mwr_elig  = i_mwr_wr_vld  && (!mwr_in_range  || !full_ext[i_mwr_wr_bar]);
    cpld_elig = i_cpld_wr_vld && (!cpld_in_range || !full_ext[i_cpld_wr_bar]);
    grant_mwr  = mwr_elig  && (!cpld_elig || !rr_ptr_q);
    grant_cpld = cpld_elig && (!mwr_elig  ||  rr_ptr_q);
    grant_any  = grant_mwr || grant_cpld;
    rr_ptr_d   = rr_ptr_q;
    if (mwr_elig && cpld_elig) rr_ptr_d = ~rr_ptr_q;
    sel_bar      = grant_cpld ? i_cpld_wr_bar : i_mwr_wr_bar;
    sel_in_range = grant_cpld ? cpld_in_range : mwr_in_range;
    sel_entry    = grant_cpld ? {i_cpld_wr_addr, i_cpld_wr_data, i_cpld_wr_be}
                              : {i_mwr_wr_addr,  i_mwr_wr_data,  i_mwr_wr_be};
    drop   = grant_any && !sel_in_range;
    drop_d = drop_q;
    if (drop && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= 1'b0;
      drop_q   <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      drop_q   <= drop_d;
    end
  end

  assign o_mwr_wr_rdy  = grant_mwr;
  assign o_cpld_wr_rdy = grant_cpld;
  assign o_drop_cnt    = drop_q;

  for (genvar k = 0; k < BAR_NUM; k++) begin : g_bar
    logic [PTR_W-1:0]   wr_q, wr_d, rd_q, rd_d, occ;
    logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
    logic               empty, pop;

    assign push[k]      = grant_any && sel_in_range && (sel_bar == 2'(k));
    // Full/empty come from registered pointers only; a same-cycle pop never frees a slot.
    assign occ          = wr_q - rd_q;
    assign empty        = (occ == '0);
    assign fifo_full[k] = (occ == PTR_W'(FIFO_DEPTH));
    assign pop          = !empty && i_bar_wr_rdy[k];
    assign wr_d         = wr_q + PTR_W'(push[k]);
    assign rd_d         = rd_q + PTR_W'(pop);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wr_q <= '0;
        rd_q <= '0;
        for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else begin
        wr_q <= wr_d;
        rd_q <= rd_d;
        if (push[k]) mem_q[wr_q[PTR_W-2:0]] <= sel_entry;
      end
    end

    assign o_bar_wr_vld[k] = !empty;
    assign {o_bar_wr_addr[k*ADDR_WIDTH +: ADDR_WIDTH],
            o_bar_wr_data[k*DATA_WIDTH +: DATA_WIDTH],
            o_bar_wr_be[k*BE_W +: BE_W]} = mem_q[rd_q[PTR_W-2:0]];

`ifdef IPS2L_PCIE_DMA_RX_ROUTER_STAT_EN
    logic [31:0] cnt_q, cnt_d;
    assign cnt_d = push[k] ? cnt_q + 32'd1 : cnt_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
    end
    assign o_bar_wr_cnt[k*32 +: 32] = cnt_q;
`else
    assign o_bar_wr_cnt[k*32 +: 32] = 32'd0;
`endif
  end

endmodule

// File: doc/ips2l_pcie_dma_rx_bar_router.md
Name: ips2l_pcie_dma_rx_bar_router

Overview:
- Parametrised successor to the fixed BAR0/BAR1/BAR2 write fan-out in the PCIe DMA RX path.
- Accepts two write streams, MWr (from the mwr write controller) and CplD (from the cpld write controller), each tagged with a BAR index.
- Arbitrates the two streams round-robin and steers each accepted write into one of BAR_NUM per-BAR FIFOs.
- Each FIFO presents a valid/ready write port to the user side, replacing the old always-enabled, unbuffered BAR outputs.

Parameters:
DATA_WIDTH, 128, write data width in bits; multiple of 32
ADDR_WIDTH, 9, write address width
BAR_NUM, 3, number of BAR output channels, 1..4
FIFO_DEPTH, 4, entries per BAR FIFO; power of 2, ≥2

Ports:
clk  in  1  core clock (gen1 62.5 MHz, gen2 125 MHz)
rst  in  1  asynchronous reset, active-high
i_mwr_wr_vld  in  1  MWr write valid
o_mwr_wr_rdy  out  1  MWr write accepted this cycle
i_mwr_wr_bar  in  2  MWr target BAR index
i_mwr_wr_addr  in  ADDR_WIDTH  MWr address
i_mwr_wr_data  in  DATA_WIDTH  MWr data
i_mwr_wr_be  in  DATA_WIDTH/8  MWr byte enables
i_cpld_wr_vld  in  1  CplD write valid
o_cpld_wr_rdy  out  1  CplD write accepted this cycle
i_cpld_wr_bar  in  2  CplD target BAR index
i_cpld_wr_addr  in  ADDR_WIDTH  CplD address
i_cpld_wr_data  in  DATA_WIDTH  CplD data
i_cpld_wr_be  in  DATA_WIDTH/8  CplD byte enables
o_bar_wr_vld  out  BAR_NUM  per-BAR FIFO not empty
i_bar_wr_rdy  in  BAR_NUM  per-BAR consumer ready
o_bar_wr_addr  out  BAR_NUM*ADDR_WIDTH  per-BAR head address; BAR k at slice k
o_bar_wr_data  out  BAR_NUM*DATA_WIDTH  per-BAR head data
o_bar_wr_be  out  BAR_NUM*DATA_WIDTH/8  per-BAR head byte enables
o_drop_cnt  out  16  writes dropped because the BAR index is ≥ BAR_NUM; saturating
o_bar_wr_cnt  out  BAR_NUM*32  per-BAR accepted-write count (optional feature)

Behaviour:
- Reset: clk and rst only; rst is asynchronous and active-high. On reset:
  - all FIFOs empty, so o_bar_wr_vld=0;
  - o_bar_wr_addr/data/be = 0;
  - o_drop_cnt = 0, o_bar_wr_cnt = 0;
  - round-robin pointer = MWr.
  - Reset asserted mid-operation discards all queued entries immediately.
- Eligibility: a source is eligible when its vld=1 and either:
  - its target BAR index is < BAR_NUM and that FIFO is not full, or
  - its target BAR index is ≥ BAR_NUM (drop path, always eligible).
- Arbitration: combinational; at most one grant per cycle.
  - Only one source eligible: that source is granted.
  - Both eligible: the source named by the pointer is granted, and the pointer flips to the other source.
  - Pointer changes only on a contested grant.
- rdy: o_x_wr_rdy = grant_x. It may depend combinationally on i_x_wr_vld. A transfer occurs on vld&rdy.
- Full rule: full is evaluated on the registered occupancy only. A pop in the same cycle does not free a slot for a push; with FIFO_DEPTH entries queued, rdy=0 even if i_bar_wr_rdy=1.
- Granted write with index < BAR_NUM: pushed to FIFO[index]. The entry appears on the outputs no earlier than the next cycle (1-cycle latency when the FIFO was empty).
- Granted write with index ≥ BAR_NUM: discarded; o_drop_cnt increments and holds at 0xFFFF.
- Outputs: each FIFO is first-word-fall-through. The head is held stable while vld=1 and rdy=0. Pop on o_bar_wr_vld[k]&i_bar_wr_rdy[k].
- Simultaneous push and pop on a non-full FIFO: occupancy unchanged, data order preserved.
- Empty FIFO: output addr/data/be are don't-care except after reset (0).
- Pointer wrap: occupancy counters are ADDR width log2(FIFO_DEPTH)+1 and wrap naturally.
- No ordering guarantee between different BARs. Within one BAR, FIFO order equals grant order.

Optional Feature:
- Macro: IPS2L_PCIE_DMA_RX_ROUTER_STAT_EN.
- Defined: o_bar_wr_cnt slice k increments on every push to FIFO k. 32-bit, wraps 0xFFFFFFFF→0, reset to 0.
- Undefined: o_bar_wr_cnt tied to 0; no counter flops.

Test Plan:
1. MWr only, bar=0, addr=0x010, data=0xA5.., be=all-ones, i_bar_wr_rdy=all 1 → o_mwr_wr_rdy=1 same cycle; o_bar_wr_vld[0]=1 next cycle with addr 0x010; popped after one cycle.
2. MWr (bar 1) and CplD (bar 2) valid for 4 cycles after reset, both FIFOs not full → grants alternate MWr, CplD, MWr, CplD; FIFO1 and FIFO2 each hold 2 entries in order.
3. i_bar_wr_rdy[0]=0, 5 MWr writes to bar 0, FIFO_DEPTH=4 → 4 accepted; 5th sees rdy=0 until one cycle after the first pop; no data lost or reordered.
4. Full FIFO0 with i_bar_wr_rdy[0]=1 and a new MWr to bar 0 → rdy=0 in the pop cycle, rdy=1 the following cycle.
5. CplD with bar=3, BAR_NUM=3, 3 writes → rdy=1 each cycle; o_drop_cnt=3; no o_bar_wr_vld asserted. With the macro defined, o_bar_wr_cnt stays 0.
6. Assert rst with FIFO1 holding 3 entries → o_bar_wr_vld=0 and o_drop_cnt=0 immediately, without waiting for a clk edge.
